// File: rtl/uart_rx.sv
// uart_rx: serial receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Latency: rvalid rises one cycle after the stop sample, which is clock edge 2+CLKS_PER_BIT/2+(9+parity)*CLKS_PER_BIT
//   after the first edge that sees the pin low.
// Backpressure: none on the serial line. A byte completing while rvalid=1 and re=0 is dropped and sets overrun.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-low reset
//   uartRxPin   asynchronous serial input, idle high
//   re          read strobe, consumes the held byte when rvalid=1
//   rdata       last received byte (held after a read)
//   rvalid      holding register has an unread byte
//   overrun     sticky, a byte was dropped; cleared by a read
//   frameError  one-cycle pulse, stop bit sampled low
//   parityError one-cycle pulse on even-parity mismatch (tied 0 without UART_RX_PARITY_EN)
//
// CLKS_PER_BIT must be even and at least 8.

module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uartRxPin,
  input  logic       re,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       overrun,
  output logic       frameError,
  output logic       parityError
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t          state, stateNext;
  logic            sync1, rxs;
  logic [CW-1:0]   sampleCnt, sampleCntNext;
  logic [2:0]      bitCnt, bitCntNext;
  logic [7:0]      shift, shiftNext;
  logic            commit;
  logic            frameErrNext;
  logic            parityErrNext;
  logic            parityBad;

`ifdef UART_RX_PARITY_EN
  logic            parityBit, parityBitNext;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parityBad = (^shift) ^ parityBit;
`else
  assign parityBad = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    stateNext     = state;
    sampleCntNext = sampleCnt;
    bitCntNext    = bitCnt;
    shiftNext     = shift;
    commit        = 1'b0;
    frameErrNext  = 1'b0;
    parityErrNext = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBitNext = parityBit;
`endif
    case (state)
      IDLE: begin
        sampleCntNext = '0;
        if (!rxs) stateNext = START;
      end
      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (sampleCnt == HALF_LAST) begin
          sampleCntNext = '0;
          bitCntNext    = '0;
          stateNext     = rxs ? IDLE : DATA;
        end else begin
          sampleCntNext = sampleCnt + CW'(1);
        end
      end
      DATA: begin
        if (sampleCnt == BIT_LAST) begin
          sampleCntNext = '0;
          shiftNext     = {rxs, shift[7:1]};  // LSB arrives first
          bitCntNext    = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end else begin
          sampleCntNext = sampleCnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sampleCnt == BIT_LAST) begin
          sampleCntNext = '0;
          parityBitNext = rxs;
          stateNext     = STOP;
        end else begin
          sampleCntNext = sampleCnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (sampleCnt == BIT_LAST) begin
          sampleCntNext = '0;
          if (!rxs) begin
            // A low stop bit may be a break; wait for the line to recover.
            frameErrNext = 1'b1;
            stateNext    = BREAK;
          end else if (parityBad) begin
            parityErrNext = 1'b1;
            stateNext     = IDLE;
          end else begin
            commit    = 1'b1;
            stateNext = IDLE;
          end
        end else begin
          sampleCntNext = sampleCnt + CW'(1);
        end
      end
      BREAK: begin
        sampleCntNext = '0;
        if (rxs) stateNext = IDLE;
      end
      default: begin
        sampleCntNext = '0;
        stateNext     = IDLE;
      end
    endcase
  end

  // State, counters, synchronizer and shift register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      sampleCnt <= '0;
      bitCnt    <= '0;
      shift     <= '0;
`ifdef UART_RX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      sync1     <= uartRxPin;
      rxs       <= sync1;
      sampleCnt <= sampleCntNext;
      bitCnt    <= bitCntNext;
      shift     <= shiftNext;
`ifdef UART_RX_PARITY_EN
      parityBit <= parityBitNext;
`endif
    end
  end

  // Holding register and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      overrun    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameError <= frameErrNext;
      if (commit) begin
        if (!rvalid || re) begin
          // A same-cycle read frees the register for the new byte.
          rdata  <= shift;
          rvalid <= 1'b1;
          if (re) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (re && rvalid) begin
        rvalid  <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (!reset) parityError <= 1'b0;
    else        parityError <= parityErrNext;
  end
`else
  assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CLKS = 104;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Edge (relative to the first edge seeing the start bit) of the stop sample.
  localparam int STOP_EDGE = 2 + CLKS / 2 + (9 + PBITS) * CLKS;
  localparam int FL = (10 + PBITS) * CLKS;  // frame length in clocks

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uartRxPin = 1'b1;
  logic       re = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, overrun, frameError, parityError;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clock(clock), .reset(reset), .uartRxPin(uartRxPin), .re(re),
    .rdata(rdata), .rvalid(rvalid), .overrun(overrun),
    .frameError(frameError), .parityError(parityError)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Per-clock line levels to replay, and what was observed during the replay.
  bit         line[$];
  int         rvFirst, feCnt, feFirst, peCnt, peFirst;
  bit         rvAfterRst;
  logic [7:0] snapRdata;
  logic       snapRvalid, snapOverrun, snapFe;
  logic [7:0] got[$];

  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) line.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stopv, input bit parFlip);
    add_level(1'b0, CLKS);
    for (int i = 0; i < 8; i++) add_level(b[i], CLKS);
    if (PBITS == 1) add_level((^b) ^ parFlip, CLKS);
    add_level(stopv, CLKS);
  endtask

  // Replays line[]; entry k is the pin level sampled at edge k.
  task automatic run_line(input bit autoRead, input int reAt, input int rstAt);
    rvFirst = -1; feCnt = 0; feFirst = -1; peCnt = 0; peFirst = -1;
    rvAfterRst = 1'b0; got.delete();
    for (int k = 0; k < line.size(); k++) begin
      uartRxPin = line[k];
      reset = !(rstAt >= 0 && k >= rstAt && k < rstAt + 4);
      re = (autoRead && rvalid) || (k == reAt);
      if (autoRead && rvalid) got.push_back(rdata);
      @(posedge clock); #1;
      if (rvalid && rvFirst < 0) rvFirst = k;
      if (frameError) begin feCnt++; if (feFirst < 0) feFirst = k; end
      if (parityError) begin peCnt++; if (peFirst < 0) peFirst = k; end
      if (rstAt >= 0 && k == rstAt) begin
        snapRdata = rdata; snapRvalid = rvalid; snapOverrun = overrun; snapFe = frameError;
      end
      if (rstAt >= 0 && k >= rstAt && rvalid) rvAfterRst = 1'b1;
    end
    re = 1'b0; reset = 1'b1; uartRxPin = 1'b1;
    line.delete();
  endtask

  task automatic do_read();
    re = 1'b1;
    @(posedge clock); #1;
    re = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_frameError: got %b expected 0", frameError); end
    checks++; if (parityError !== 1'b0) begin errors++; $display("FAIL reset_parityError: got %b expected 0", parityError); end
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    add_frame(8'h55, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, -1, -1);
    checks++; if (rvFirst !== STOP_EDGE) begin errors++; $display("FAIL basic_rvalid_edge: got %0d expected %0d", rvFirst, STOP_EDGE); end
    checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL basic_rdata: got %h expected 55", rdata); end
    checks++; if (feCnt !== 0 || peCnt !== 0) begin errors++; $display("FAIL basic_pulses: fe %0d pe %0d expected 0 0", feCnt, peCnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
    do_read();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL basic_read_clears: rvalid %b expected 0", rvalid); end
    checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL basic_rdata_held: got %h expected 55", rdata); end
  endtask

  task automatic test_glitch();
    add_level(1'b0, 30);
    add_level(1'b1, 200);
    add_frame(8'hA3, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, -1, -1);
    checks++; if (rvFirst !== 230 + STOP_EDGE) begin errors++; $display("FAIL glitch_rvalid_edge: got %0d expected %0d", rvFirst, 230 + STOP_EDGE); end
    checks++; if (rdata !== 8'hA3) begin errors++; $display("FAIL glitch_rdata: got %h expected a3", rdata); end
    checks++; if (feCnt !== 0) begin errors++; $display("FAIL glitch_fe: got %0d pulses expected 0", feCnt); end
    do_read();
  endtask

  task automatic test_frame_error();
    int s2;
    add_frame(8'h0F, 1'b0, 1'b0);
    add_level(1'b0, CLKS);       // line stays low for two bit times in total
    add_level(1'b1, 2 * CLKS);
    s2 = line.size();
    add_frame(8'h3C, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, -1, -1);
    checks++; if (feFirst !== STOP_EDGE) begin errors++; $display("FAIL fe_edge: got %0d expected %0d", feFirst, STOP_EDGE); end
    checks++; if (feCnt !== 1) begin errors++; $display("FAIL fe_width: got %0d cycles expected 1", feCnt); end
    checks++; if (rvFirst !== s2 + STOP_EDGE) begin errors++; $display("FAIL fe_next_rvalid_edge: got %0d expected %0d", rvFirst, s2 + STOP_EDGE); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL fe_next_rdata: got %h expected 3c", rdata); end
    do_read();
  endtask

  task automatic test_overrun();
    int s2;
    add_frame(8'h11, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    s2 = line.size();
    add_frame(8'h22, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, -1, -1);
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL ovr_rdata: got %h expected 11", rdata); end
    checks++; if (overrun !== 1'b1 || rvalid !== 1'b1) begin errors++; $display("FAIL ovr_flags: overrun %b rvalid %b expected 1 1", overrun, rvalid); end
    do_read();
    checks++; if (overrun !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL ovr_read_clear: overrun %b rvalid %b expected 0 0", overrun, rvalid); end

    // Read landing on the commit edge of the second byte.
    add_frame(8'h11, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    add_frame(8'h22, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, s2 + STOP_EDGE, -1);
    checks++; if (rdata !== 8'h22 || rvalid !== 1'b1) begin errors++; $display("FAIL ovr_same_cycle: rdata %h rvalid %b expected 22 1", rdata, rvalid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_same_cycle_overrun: got %b expected 0", overrun); end
    do_read();
  endtask

  task automatic test_reset_midframe();
    int s2, rstAt;
    logic [7:0] a, b;
    a = 8'($urandom_range(1, 255));
    b = 8'hF0 | 8'($urandom_range(0, 15));  // upper bits high: no false start after reset
    add_frame(a, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    s2 = line.size();
    add_frame(b, 1'b1, 1'b0);
    add_level(1'b1, 3 * CLKS);
    rstAt = s2 + 5 * CLKS + 40;           // middle of data bit 4
    run_line(1'b0, -1, rstAt);
    checks++; if (snapRdata !== 8'h00 || snapRvalid !== 1'b0 || snapOverrun !== 1'b0 || snapFe !== 1'b0)
      begin errors++; $display("FAIL rst_mid_outputs: rdata %h rvalid %b overrun %b fe %b expected 00 0 0 0", snapRdata, snapRvalid, snapOverrun, snapFe); end
    checks++; if (rvAfterRst !== 1'b0 || feCnt !== 0 || peCnt !== 0)
      begin errors++; $display("FAIL rst_mid_no_activity: rvalid_seen %b fe %0d pe %0d expected 0 0 0", rvAfterRst, feCnt, peCnt); end
    add_frame(8'hC8, 1'b1, 1'b0);
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, -1, -1);
    checks++; if (rvFirst !== STOP_EDGE || rdata !== 8'hC8) begin errors++; $display("FAIL rst_mid_next: edge %0d rdata %h expected %0d c8", rvFirst, rdata, STOP_EDGE); end
    do_read();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom());
      exp.push_back(b);
      add_frame(b, 1'b1, 1'b0);         // next start bit follows the stop bit directly
    end
    add_level(1'b1, 2 * CLKS);
    run_line(1'b1, -1, -1);
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL b2b_count: got %0d bytes expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], exp[i]); end
    end
    checks++; if (rvFirst !== STOP_EDGE) begin errors++; $display("FAIL b2b_first_edge: got %0d expected %0d", rvFirst, STOP_EDGE); end
    checks++; if (feCnt !== 0 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_errors: fe %0d overrun %b expected 0 0", feCnt, overrun); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    add_frame(8'h07, 1'b1, 1'b0);       // correct even parity bit is 1
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, -1, -1);
    checks++; if (rvFirst !== 1094 || rdata !== 8'h07) begin errors++; $display("FAIL par_good: edge %0d rdata %h expected 1094 07", rvFirst, rdata); end
    checks++; if (peCnt !== 0) begin errors++; $display("FAIL par_good_pe: got %0d expected 0", peCnt); end
    do_read();
    add_frame(8'h07, 1'b1, 1'b1);       // wrong parity bit
    add_level(1'b1, 2 * CLKS);
    run_line(1'b0, -1, -1);
    checks++; if (peCnt !== 1 || peFirst !== 1094) begin errors++; $display("FAIL par_bad_pulse: count %0d edge %0d expected 1 1094", peCnt, peFirst); end
    checks++; if (rvFirst !== -1) begin errors++; $display("FAIL par_bad_rvalid: edge %0d expected none", rvFirst); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
